// File: rtl/pulse_sync_sched_pkg.sv
// Shared types and width helpers for the pulse synchronizer scheduler.
// Pure declarations: no latency, no flow control.
package pulse_sync_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // One counter is shared by the timeout and guard phases, so it is sized for the larger.
    function automatic int unsigned cnt_width(input int unsigned tmo, input int unsigned gap);
        return clog2w((tmo > gap) ? tmo : gap);
    endfunction

    localparam int unsigned DEF_TMO  = 64;
    localparam int unsigned DEF_GAP  = 6;
    localparam int unsigned DEF_CNTW = cnt_width(DEF_TMO, DEF_GAP);

endpackage

// File: rtl/pulse_sync_sched_rr_arb.sv
// Combinational round-robin pick of the first set pend bit at or above ptr, wrapping.
// Latency: zero cycles; backpressure: none, the caller decides whether to take the grant.
module rr_arb
    import pulse_sync_sched_pkg::*;
#(
    parameter int pN   = 4,
    parameter int pIDW = 2
) (
    input  logic [pN-1:0]   pend,
    input  logic [pIDW-1:0] ptr,
    output logic            vld,
    output logic [pIDW-1:0] idx
);

    function automatic logic [pIDW-1:0] cand_of(input logic [pIDW-1:0] p, input int k);
        int j;
        j = int'(p) + k;
        if (j >= pN) j = j - pN;
        return pIDW'(j);
    endfunction

    // Scan from the far end so the candidate closest to ptr is written last and wins.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int k = pN - 1; k >= 0; k--) begin
            if (pend[cand_of(ptr, k)]) begin
                vld = 1'b1;
                idx = cand_of(ptr, k);
            end
        end
    end

endmodule

// File: rtl/pulse_sync_sched.sv
// Shares one pulse synchronizer among pN requesters: latch, round-robin grant, pulse, await ack/timeout, guard gap.
// Latency: req to src_pls is 2 cycles when idle; backpressure: repeat events on a pending requester coalesce into drop_cnt.
module pulse_sync_sched
    import pulse_sync_sched_pkg::*;
#(
    parameter int pN    = 4,
    parameter int pIDW  = 2,
    parameter int pGAP  = 6,
    parameter int pTMO  = 64,
    parameter int pCNTW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [pN-1:0]    req,
    input  logic             ack_pls,
    input  logic             drop_clr,
    output logic             src_pls,
    output logic [pIDW-1:0]  evt_id,
    output logic [pN-1:0]    pend,
    output logic             busy,
    output logic             tmo_err,
    output logic [pCNTW-1:0] drop_cnt
);

    localparam int unsigned     CNTW      = cnt_width(pTMO, pGAP);
    localparam logic [CNTW-1:0] TMO_LAST  = CNTW'(pTMO - 1);
    localparam logic [CNTW-1:0] GAP_LAST  = CNTW'(pGAP - 1);
    localparam state_t          AFTER_ACK = (pGAP == 0) ? IDLE : GAP;
    localparam int unsigned     DROP_MAX  = (1 << pCNTW) - 1;

    state_t            state, state_nxt;
    logic [CNTW-1:0]   cnt, cnt_nxt;
    logic [pIDW-1:0]   ptr;
    logic              arb_vld;
    logic [pIDW-1:0]   arb_idx;
    logic              grant;
    logic              tmo_hit;
    logic [pN-1:0]     clr;
    logic [pN-1:0]     drop;
    logic [pN-1:0]     pend_nxt;
    int unsigned       n_drop;
    int unsigned       drop_sum;
    logic [pCNTW-1:0]  drop_cnt_nxt;

    rr_arb #(
        .pN   (pN),
        .pIDW (pIDW)
    ) u_arb (
        .pend (pend),
        .ptr  (ptr),
        .vld  (arb_vld),
        .idx  (arb_idx)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && arb_vld) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_ACK;
                cnt_nxt   = '0;
            end
            WAIT_ACK: begin
                // An ack on the last timeout cycle takes priority over the timeout.
                if (ack_pls) begin
                    state_nxt = AFTER_ACK;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = AFTER_ACK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A request landing on the grant cycle of the same requester is a fresh event, not a drop.
    always_comb begin
        clr      = grant ? (pN'(1) << arb_idx) : '0;
        drop     = req & pend & ~clr;
        pend_nxt = req | (pend & ~clr);
        n_drop   = 0;
        for (int i = 0; i < pN; i++) begin
            n_drop = n_drop + 32'(drop[i]);
        end
        drop_sum     = 32'(drop_cnt) + n_drop;
        drop_cnt_nxt = (drop_sum > DROP_MAX) ? pCNTW'(DROP_MAX) : pCNTW'(drop_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= '0;
            ptr      <= '0;
            src_pls  <= 1'b0;
            evt_id   <= '0;
            busy     <= 1'b0;
            tmo_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            src_pls  <= (state_nxt == ISSUE);
            busy     <= (state_nxt != IDLE);
            tmo_err  <= tmo_hit;
            drop_cnt <= drop_clr ? '0 : drop_cnt_nxt;
            if (grant) begin
                evt_id <= arb_idx;
                ptr    <= (arb_idx == pIDW'(pN - 1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

endmodule
